match_reporter: RTL



---
 rtl/match_pkg.sv | 17 +
 rtl/prio_enc_hi.sv | 30 +++
 rtl/match_reporter.sv | 109 ++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// match_pkg: constants and state type shared by the pattern matcher and match_reporter.
//   TEXT_W / PAT_W : text word and pattern widths
//   NPOS / POS_W   : number of alignment positions and width of a position index
//   state_e        : reporter state encoding {IDLE, EMIT}
package match_pkg;

  localparam int unsigned TEXT_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned NPOS   = TEXT_W - PAT_W + 1;
  localparam int unsigned POS_W  = $clog2(NPOS);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/prio_enc_hi.sv
// prio_enc_hi: combinational highest-set-bit encoder over an NPOS-bit vector.
// Ports:
//   i_vec    : input vector
//   o_idx    : index of the highest set bit (0 when i_vec is zero)
//   o_zero   : i_vec has no bit set
//   o_single : i_vec has at most one bit set
module prio_enc_hi
  import match_pkg::*;
(
  input  logic [NPOS-1:0]  i_vec,
  output logic [POS_W-1:0] o_idx,
  output logic             o_zero,
  output logic             o_single
);

  localparam logic [NPOS-1:0] VecOne = 1;

  // Ascending scan: the last set bit visited wins, i.e. the highest one.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < int'(NPOS); i++) begin
      if (i_vec[i]) o_idx = POS_W'(i);
    end
  end

  assign o_zero   = (i_vec == '0);
  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  assign o_single = ((i_vec & (i_vec - VecOne)) == '0);

endmodule

// File: rtl/match_reporter.sv
// match_reporter: serialises a per-word match vector into position reports,
// highest position first, with one "no match" report for words without hits.
// Build option: define MATCH_REPORTER_COUNT_EN to build the word/hit counters;
// otherwise word_count and hit_count are tied to 0.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : match vector handshake; in_hit vector, in_any flag
//   out_valid/out_ready       : report handshake; out_pos, out_none, out_last
//   err_any                   : sticky, in_any disagreed with |in_hit on an accept
//   word_count, hit_count     : saturating counts of accepted words / reported hits
module match_reporter
  import match_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NPOS-1:0]  in_hit,
  input  logic             in_any,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_none,
  output logic             out_last,
  output logic             err_any,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [NPOS-1:0] PendOne = 1;

  state_e            r_state, w_state_d;
  logic [NPOS-1:0]   r_pend, w_pend_d;
  logic              r_err;
  logic [POS_W-1:0]  w_idx;
  logic              w_zero;
  logic              w_single;
  logic              w_accept;
  logic              w_out_hs;

  prio_enc_hi u_enc (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_zero   (w_zero),
    .o_single (w_single)
  );

  assign out_valid = (r_state == EMIT);
  assign out_pos   = out_valid ? w_idx : '0;
  assign out_none  = out_valid & w_zero;
  assign out_last  = out_valid & w_single;
  assign w_out_hs  = out_valid & out_ready;
  // Taking the next word on the last handshake removes the bubble between words.
  assign in_ready  = (r_state == IDLE) | (w_out_hs & out_last);
  assign w_accept  = in_valid & in_ready;
  assign err_any   = r_err;

  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    if (w_out_hs) begin
      // idx is 0 when pend is empty, but then bit 0 is already clear.
      w_pend_d = r_pend & ~(PendOne << w_idx);
      if (out_last) w_state_d = IDLE;
    end
    if (w_accept) begin
      w_pend_d  = in_hit;
      w_state_d = EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
      if (w_accept && (in_any != (|in_hit))) r_err <= 1'b1;
    end
  end

`ifdef MATCH_REPORTER_COUNT_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_hit_cnt  <= '0;
    end else begin
      if (w_accept && !(&r_word_cnt)) r_word_cnt <= r_word_cnt + CntOne;
      if (w_out_hs && !out_none && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CntOne;
    end
  end

  assign word_count = r_word_cnt;
  assign hit_count  = r_hit_cnt;
`else
  assign word_count = '0;
  assign hit_count  = '0;
`endif

endmodule
